// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: filters the raw lines, decodes 11-bit frames and tracks the held key code.
// Optional saturating frame-error counter enabled by defining PS2_ERR_CNT_EN.
module ps2_scancode_rx #(
  parameter int WIDTH      = 16,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_ps2_clk,
  input  logic             i_ps2_data,
  output logic [WIDTH-1:0] o_key_code,
  output logic             o_key_valid,
  output logic             o_frame_err,
  output logic [7:0]       o_err_count
);

  localparam int FC_W = $clog2(FILTER_LEN + 1);
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [FC_W-1:0] FC_MAX = FC_W'(FILTER_LEN - 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic            r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic            r_filt, r_filt_q, r_fall;
  logic [FC_W-1:0] r_fcnt;
  logic [TO_W-1:0] r_to_cnt;
  state_t          r_state, w_state_nxt;
  logic [2:0]      r_bitcnt;
  logic [7:0]      r_shift;
  logic            r_par_ok;
  logic            w_good, w_err, w_timeout;
  logic            r_byte_vld;
  logic [7:0]      r_byte;
  logic            r_ext_pend, r_brk_pend;
  logic [WIDTH-1:0] r_key_code;
  logic            r_key_valid, r_frame_err;
  logic [8:0]      w_code;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
      r_filt   <= 1'b1;
      r_filt_q <= 1'b1;
      r_fall   <= 1'b0;
      r_fcnt   <= '0;
    end else begin
      r_clk_s1 <= i_ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= i_ps2_data;
      r_dat_s2 <= r_dat_s1;
      // Level only flips after FILTER_LEN consecutive disagreeing samples.
      if (r_clk_s2 != r_filt) begin
        if (r_fcnt == FC_MAX) begin
          r_filt <= r_clk_s2;
          r_fcnt <= '0;
        end else begin
          r_fcnt <= r_fcnt + FC_W'(1);
        end
      end else begin
        r_fcnt <= '0;
      end
      r_filt_q <= r_filt;
      r_fall   <= r_filt_q & ~r_filt;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A fall in the same cycle as the timeout wins, so no error is raised.
  always_comb begin
    w_state_nxt = r_state;
    w_good      = 1'b0;
    w_err       = 1'b0;
    w_timeout   = (r_state != S_IDLE) && !r_fall && (r_to_cnt == TO_MAX);
    if (w_timeout) begin
      w_state_nxt = S_IDLE;
      w_err       = 1'b1;
    end else if (r_fall) begin
      case (r_state)
        S_IDLE:   if (!r_dat_s2) w_state_nxt = S_DATA;
        S_DATA:   if (r_bitcnt == 3'd7) w_state_nxt = S_PARITY;
        S_PARITY: w_state_nxt = S_STOP;
        S_STOP: begin
          w_state_nxt = S_IDLE;
          if (r_dat_s2 && r_par_ok) w_good = 1'b1;
          else                      w_err  = 1'b1;
        end
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_par_ok    <= 1'b0;
      r_to_cnt    <= '0;
      r_byte_vld  <= 1'b0;
      r_byte      <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_byte_vld  <= w_good;
      r_frame_err <= w_err;
      if (w_good) r_byte <= r_shift;
      if (r_fall || r_state == S_IDLE) r_to_cnt <= '0;
      else if (r_to_cnt != TO_MAX)     r_to_cnt <= r_to_cnt + TO_W'(1);
      if (r_fall) begin
        case (r_state)
          S_IDLE: r_bitcnt <= '0;
          S_DATA: begin
            r_shift  <= {r_dat_s2, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
          end
          S_PARITY: r_par_ok <= ^{r_shift, r_dat_s2};
          default: ;
        endcase
      end
    end
  end

  assign w_code = {r_ext_pend, r_byte};

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_ext_pend  <= 1'b0;
      r_brk_pend  <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      if (r_byte_vld) begin
        if (r_byte == 8'hE0) begin
          r_ext_pend <= 1'b1;
        end else if (r_byte == 8'hF0) begin
          r_brk_pend <= 1'b1;
        end else begin
          // Releases of keys other than the held one are ignored.
          if (r_brk_pend) begin
            if (w_code == r_key_code[8:0]) begin
              r_key_code  <= '0;
              r_key_valid <= 1'b1;
            end
          end else if (w_code != r_key_code[8:0]) begin
            r_key_code  <= {{(WIDTH-9){1'b0}}, w_code};
            r_key_valid <= 1'b1;
          end
          r_ext_pend <= 1'b0;
          r_brk_pend <= 1'b0;
        end
      end
    end
  end

`ifdef PS2_ERR_CNT_EN
  logic [7:0] r_err_count;
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_err_count <= '0;
    end else if (r_frame_err && r_err_count != 8'hFF) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end
  assign o_err_count = r_err_count;
`else
  assign o_err_count = 8'd0;
`endif

  assign o_key_code  = r_key_code;
  assign o_key_valid = r_key_valid;
  assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: key_valid events checked against a queue of expected key codes.
module tb_ps2_scancode_rx;
  localparam int HALF  = 40;
  localparam int TB_TO = 2000;

  logic        clk, rst_n, ps2_clk, ps2_data;
  logic [15:0] key_code;
  logic        key_valid, frame_err;
  logic [7:0]  err_count;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_ferr  = 0;
  int          exp_ferr = 0;
  int          exp_cnt  = 0;
  logic [15:0] exp_q[$];

  ps2_scancode_rx #(.WIDTH(16), .FILTER_LEN(8), .TIMEOUT(TB_TO)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_ps2_clk(ps2_clk), .i_ps2_data(ps2_data),
    .o_key_code(key_code), .o_key_valid(key_valid), .o_frame_err(frame_err),
    .o_err_count(err_count)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && frame_err) n_ferr++;
    if (rst_n && key_valid) begin
      check("kv_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("kv_key_code", key_code, exp_q.pop_front());
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ flip_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 11);
    ps2_data = 1'b1;
    wait_cyc(2 * HALF);
  endtask

  task automatic check_state(input string tag, input logic [15:0] exp_key);
    check({tag, "_key"}, key_code, exp_key);
    check({tag, "_qdrain"}, exp_q.size(), 0);
    check({tag, "_ferr"}, n_ferr, exp_ferr);
`ifdef PS2_ERR_CNT_EN
    check({tag, "_errcnt"}, err_count, exp_cnt);
`else
    check({tag, "_errcnt"}, err_count, 0);
`endif
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    wait_cyc(5);
    check("rst_key", key_code, 0);
    check("rst_valid", key_valid, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_errcnt", err_count, 0);
    rst_n = 1'b1;
    wait_cyc(20);

    exp_q.push_back(16'h001C);
    send(8'h1C);
    check_state("make_1c", 16'h001C);

    send(8'h1C); send(8'h1C);
    check_state("typematic", 16'h001C);
    exp_q.push_back(16'h0000);
    send(8'hF0); send(8'h1C);
    check_state("break_1c", 16'h0000);

    exp_q.push_back(16'h0175);
    send(8'hE0); send(8'h75);
    check_state("ext_make", 16'h0175);
    send(8'hF0); send(8'h75);
    check_state("nonext_break", 16'h0175);
    exp_q.push_back(16'h0000);
    send(8'hE0); send(8'hF0); send(8'h75);
    check_state("ext_break", 16'h0000);

    exp_ferr++; exp_cnt++;
    send_frame(8'h29, 1'b1, 11);
    ps2_data = 1'b1;
    wait_cyc(2 * HALF);
    check_state("parity_err", 16'h0000);
    exp_q.push_back(16'h0029);
    send(8'h29);
    check_state("after_perr", 16'h0029);

    send_frame(8'h55, 1'b0, 5);
    ps2_data = 1'b1;
    wait_cyc(TB_TO - 200 - HALF);
    check("timeout_early", n_ferr, exp_ferr);
    exp_ferr++; exp_cnt++;
    wait_cyc(400);
    check_state("timeout", 16'h0029);
    exp_q.push_back(16'h0023);
    send(8'h23);
    check_state("after_to", 16'h0023);

    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    wait_cyc(3);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(TB_TO + 100);
    check_state("glitch", 16'h0023);
    exp_q.push_back(16'h001C);
    send(8'h1C);
    check_state("after_glitch", 16'h001C);

    send_frame(8'h34, 1'b0, 4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_key", key_code, 0);
    check("midrst_valid", key_valid, 0);
    check("midrst_ferr", frame_err, 0);
    check("midrst_errcnt", err_count, 0);
    ps2_clk = 1'b1; ps2_data = 1'b1;
    exp_cnt = 0;
    wait_cyc(5);
    rst_n = 1'b1;
    wait_cyc(20);
    exp_q.push_back(16'h0034);
    send(8'h34);
    check_state("after_rst", 16'h0034);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
